dut_stage_sequencer: RTL and testbench
======================================

// Module: dut_stage_sequencer
// PURPOSE
//  Top-level ap_ctrl_hs sequencer that runs the dut sub-blocks (Pipeline_1..3, VITIS_LOOP_38_1, VITIS_LOOP_73_2) strictly in index order.
//  Drives each child's ap_start, waits for its ap_done, records per-stage cycle counts, enforces an optional watchdog.
//  Sits between the testbench/host ap_* handshake and the grp_* child instances; its ap_* pins are what dataflow_monitor probes.
// PARAMETERS
//  N_STAGES  5   number of sequenced child blocks (>=1)
//  CNT_W     32  width of stage cycle counter / timeout
//  TIMEOUT   0   watchdog limit in cycles per stage; 0 disables
// PORTS
//  clock               in   1         single clock; all state on rising edge
//  reset_n             in   1         asynchronous, active-low reset
//  ap_start            in   1         run request (level, ap_ctrl_hs)
//  stage_en            in   N_STAGES  stage enable mask, sampled when ap_start accepted
//  ap_ready            out  1         1-cycle pulse: request accepted, stage_en captured
//  ap_done             out  1         1-cycle pulse: run complete (or aborted)
//  ap_idle             out  1         1 while in IDLE
//  child_start         out  N_STAGES  one-hot ap_start to children
//  child_done          in   N_STAGES  ap_done from children
//  cur_stage           out  $clog2(N_STAGES)  index of stage in RUN (holds last value otherwise)
//  stage_cycles        out  CNT_W     cycle count of last finished stage
//  stage_cycles_valid  out  1         1-cycle pulse with stage_cycles
//  timeout_err         out  1         sticky; set on watchdog abort, cleared on next accepted ap_start
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, ap_idle=1; all other outputs 0; remaining-mask 0; counter 0.
//  States: IDLE -> SELECT -> RUN -> SELECT ... -> DONE -> IDLE.
//  IDLE: on ap_start=1 -> remaining<=stage_en, timeout_err<=0, ap_ready=1 next cycle, go SELECT.
//  SELECT (1 cycle): remaining==0 -> DONE; else cur_stage<=lowest set bit of remaining, counter<=1, go RUN.
//  RUN: child_start[cur_stage]=1 (only that bit), held until child_done[cur_stage] sampled 1.
//   - done: child_start drops same edge; clear remaining[cur_stage]; stage_cycles<=counter,
//     stage_cycles_valid=1 next cycle; go SELECT. Done in the first RUN cycle -> stage_cycles=1.
//   - counter increments each RUN cycle, saturates at 2^CNT_W-1.
//   - TIMEOUT!=0 and counter==TIMEOUT with no done: drop child_start, timeout_err<=1,
//     remaining<=0, stage_cycles<=TIMEOUT with valid pulse, go DONE (remaining stages skipped).
//   - child_done on non-current bits ignored in all states.
//  DONE (1 cycle): ap_done=1 -> IDLE. ap_start high during DONE is not accepted until IDLE.
//  Latency: empty mask -> ap_done 3 cycles after accept edge; k enabled stages add sum(stage_cycles)+1 each.
//  Back-to-back: ap_start held high -> new run accepted the cycle after DONE (IDLE visited 1 cycle).
//  Reset mid-RUN: child_start drops immediately (async), no ap_done issued.
// STRUCTURE
//  Package dut_seq_pkg: seq_state_e {IDLE,SELECT,RUN,DONE}, localparam function idx_w(N).
//  Sub-module seq_lowest_bit #(N): combinational lowest-set-bit index + any flag over remaining mask.
//  Remaining logic (FSM, counter, watchdog, outputs) in this module, single always_ff + always_comb.
// TESTING
//  T1 stage_en=5'b11111, each child_done 4 cycles after its start -> child_start 1,2,4,8,16 in order,
//     five stage_cycles=4 pulses, ap_done once, timeout_err=0.
//  T2 stage_en=5'b00000 -> ap_ready then ap_done 3 cycles after accept, child_start never asserted.
//  T3 stage_en=5'b10100, child_done same cycle as start -> only stages 2 and 4 run, stage_cycles=1 each.
//  T4 TIMEOUT=10, stage 1 never done, stage_en=5'b00111 -> stage 0 completes, stage 1 aborted at 10 cycles,
//     timeout_err=1, stage 2 never started, ap_done pulses; next ap_start clears timeout_err.
//  T5 reset_n pulled low mid stage 3 -> child_start=0 and ap_idle=1 asynchronously, no ap_done;
//     fresh run after release behaves as T1.
//  T6 ap_start held high for 3 runs with spurious child_done on idle bits -> 3 ap_ready/ap_done pairs,
//     spurious dones ignored, stage order unchanged.

Source files
------------

// File: rtl/dut_seq_pkg.sv
// Shared types and helpers for the stage sequencer: FSM state encoding and
// the index-width helper used to size the current-stage field.
package dut_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // Width of a stage index; never narrower than one bit so a single-stage
  // build still has a legal cur_stage vector.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dut_stage_sequencer_if.sv
// Host-side ap_ctrl_hs handshake plus the child start/done fan-out of the
// stage sequencer. The master side requests runs and returns child dones;
// the slave side is the sequencer itself.
interface dut_stage_sequencer_if #(
  parameter int N_STAGES = 5,
  parameter int CNT_W    = 32
);
  import dut_seq_pkg::*;

  localparam int IW = idx_w(N_STAGES);

  logic                ap_start;
  logic [N_STAGES-1:0] stage_en;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_idle;
  logic [N_STAGES-1:0] child_start;
  logic [N_STAGES-1:0] child_done;
  logic [IW-1:0]       cur_stage;
  logic [CNT_W-1:0]    stage_cycles;
  logic                stage_cycles_valid;
  logic                timeout_err;

  modport master (
    output ap_start, stage_en, child_done,
    input  ap_ready, ap_done, ap_idle, child_start, cur_stage,
           stage_cycles, stage_cycles_valid, timeout_err
  );

  modport slave (
    input  ap_start, stage_en, child_done,
    output ap_ready, ap_done, ap_idle, child_start, cur_stage,
           stage_cycles, stage_cycles_valid, timeout_err
  );

endinterface

// File: rtl/dut_stage_sequencer_lowest_bit.sv
// Priority picker: index of the lowest set bit of the remaining-stage mask,
// plus a flag telling whether any stage is still pending.
module seq_lowest_bit #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] idx_s;

  // Scan from the top down so the last hit, the lowest bit, wins.
  always_comb begin
    idx_s = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx_s = mask[i] ? IW'(i) : idx_s;
    end
  end

  assign idx = idx_s;
  assign any = |mask;

endmodule

// File: rtl/dut_stage_sequencer.sv
// Top-level ap_ctrl_hs sequencer. Runs the enabled child blocks one at a
// time in index order, measures how many cycles each one took, and can
// abort a run when a child exceeds the per-stage watchdog limit.
module dut_stage_sequencer
  import dut_seq_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  dut_stage_sequencer_if.slave bus
);

  localparam int               IW        = idx_w(N_STAGES);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic             WDOG_EN   = (TIMEOUT != 0);

  // One-hot start vector for a given stage index.
  function automatic logic [N_STAGES-1:0] onehot(input logic [IW-1:0] idx);
    return N_STAGES'(1) << idx;
  endfunction

  seq_state_e          state_r,        state_s;
  logic [N_STAGES-1:0] remaining_r,    remaining_s;
  logic [CNT_W-1:0]    counter_r,      counter_s;
  logic [IW-1:0]       cur_stage_r,    cur_stage_s;
  logic [N_STAGES-1:0] child_start_r,  child_start_s;
  logic                ap_ready_r,     ap_ready_s;
  logic                ap_done_r,      ap_done_s;
  logic                ap_idle_r,      ap_idle_s;
  logic [CNT_W-1:0]    stage_cycles_r, stage_cycles_s;
  logic                valid_r,        valid_s;
  logic                timeout_err_r,  timeout_err_s;

  logic [IW-1:0]       low_idx_s;
  logic                any_s;
  logic                cur_done_s;
  logic                timeout_hit_s;

  seq_lowest_bit #(
    .N  (N_STAGES),
    .IW (IW)
  ) u_lowest (
    .mask (remaining_r),
    .idx  (low_idx_s),
    .any  (any_s)
  );

  // Only the child currently being started can finish the stage; dones on
  // any other bit are masked off by the one-hot start vector.
  assign cur_done_s    = |(bus.child_done & child_start_r);
  assign timeout_hit_s = WDOG_EN && (counter_r == TIMEOUT_C);

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_s        = state_r;
    remaining_s    = remaining_r;
    counter_s      = counter_r;
    cur_stage_s    = cur_stage_r;
    child_start_s  = child_start_r;
    ap_ready_s     = 1'b0;
    ap_done_s      = 1'b0;
    valid_s        = 1'b0;
    stage_cycles_s = stage_cycles_r;
    timeout_err_s  = timeout_err_r;

    case (state_r)
      IDLE: begin
        if (bus.ap_start) begin
          remaining_s   = bus.stage_en;
          timeout_err_s = 1'b0;
          ap_ready_s    = 1'b1;
          state_s       = SELECT;
        end else begin
          state_s = IDLE;
        end
      end

      SELECT: begin
        if (!any_s) begin
          state_s = DONE;
        end else begin
          cur_stage_s   = low_idx_s;
          counter_s     = CNT_ONE;
          child_start_s = onehot(low_idx_s);
          state_s       = RUN;
        end
      end

      RUN: begin
        if (cur_done_s) begin
          // Completion wins over a watchdog hit in the same cycle.
          child_start_s  = {N_STAGES{1'b0}};
          remaining_s    = remaining_r & ~child_start_r;
          stage_cycles_s = counter_r;
          valid_s        = 1'b1;
          state_s        = SELECT;
        end else if (timeout_hit_s) begin
          // Abort: the stuck stage and all later ones are skipped.
          child_start_s  = {N_STAGES{1'b0}};
          remaining_s    = {N_STAGES{1'b0}};
          stage_cycles_s = TIMEOUT_C;
          valid_s        = 1'b1;
          timeout_err_s  = 1'b1;
          state_s        = DONE;
        end else begin
          counter_s = (counter_r == CNT_MAX) ? counter_r : counter_r + CNT_ONE;
          state_s   = RUN;
        end
      end

      DONE: begin
        ap_done_s = 1'b1;
        state_s   = IDLE;
      end

      default: begin
        child_start_s = {N_STAGES{1'b0}};
        remaining_s   = {N_STAGES{1'b0}};
        state_s       = IDLE;
      end
    endcase

    ap_idle_s = (state_s == IDLE) ? 1'b1 : 1'b0;
  end

  // State and registered-output update; reset forces IDLE and drops every
  // child start immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      remaining_r    <= {N_STAGES{1'b0}};
      counter_r      <= {CNT_W{1'b0}};
      cur_stage_r    <= {IW{1'b0}};
      child_start_r  <= {N_STAGES{1'b0}};
      ap_ready_r     <= 1'b0;
      ap_done_r      <= 1'b0;
      ap_idle_r      <= 1'b1;
      stage_cycles_r <= {CNT_W{1'b0}};
      valid_r        <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      remaining_r    <= remaining_s;
      counter_r      <= counter_s;
      cur_stage_r    <= cur_stage_s;
      child_start_r  <= child_start_s;
      ap_ready_r     <= ap_ready_s;
      ap_done_r      <= ap_done_s;
      ap_idle_r      <= ap_idle_s;
      stage_cycles_r <= stage_cycles_s;
      valid_r        <= valid_s;
      timeout_err_r  <= timeout_err_s;
    end
  end

  assign bus.ap_ready           = ap_ready_r;
  assign bus.ap_done            = ap_done_r;
  assign bus.ap_idle            = ap_idle_r;
  assign bus.child_start        = child_start_r;
  assign bus.cur_stage          = cur_stage_r;
  assign bus.stage_cycles       = stage_cycles_r;
  assign bus.stage_cycles_valid = valid_r;
  assign bus.timeout_err        = timeout_err_r;

endmodule

// File: tb/tb_dut_stage_sequencer.sv
// Self-checking bench for dut_stage_sequencer: table of run vectors with
// hand-computed order/cycle/latency expectations, plus hand-written
// sequences for mid-run reset and back-to-back runs.
module tb_dut_stage_sequencer;

  localparam int N  = 5;
  localparam int CW = 32;
  localparam int TO = 10;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  dut_stage_sequencer_if #(.N_STAGES(N), .CNT_W(CW)) bus_if ();

  dut_stage_sequencer #(
    .N_STAGES (N),
    .CNT_W    (CW),
    .TIMEOUT  (TO)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  typedef struct {
    logic [4:0]      en;
    logic [4:0][7:0] lat;     // child latency per stage, 0 = never done
    logic [4:0]      spur;    // constant done on non-started bits
    int              n_exp;   // stages expected to start
    logic [4:0][2:0] order;   // expected start order, position 0 first
    logic [4:0][7:0] cyc;     // expected stage_cycles per position
    int              exp_lat; // accept edge to edge sampling ap_done
    logic            exp_to;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [4:0][7:0] lat_cfg  = '0;
  logic [4:0]      spur_cfg = 5'd0;
  int              run_cnt [5];

  int   start_q [$];
  int   cur_q   [$];
  int   cyc_q   [$];
  int   done_total  = 0;
  int   multi_total = 0;
  logic [4:0] prev_start = 5'd0;
  int   acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] en, input logic [4:0][7:0] lat,
                               input logic [4:0] spur, input int n_exp,
                               input logic [4:0][2:0] order, input logic [4:0][7:0] cyc_e,
                               input int exp_lat, input logic exp_to);
    vec_t v;
    v.en = en; v.lat = lat; v.spur = spur; v.n_exp = n_exp;
    v.order = order; v.cyc = cyc_e; v.exp_lat = exp_lat; v.exp_to = exp_to;
    return v;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Child model: done after lat_cfg[i] cycles of its start, spurious otherwise.
  always @(negedge clock) begin : child_model
    logic [4:0] d;
    int c;
    for (int i = 0; i < 5; i++) begin
      if (bus_if.child_start[i] === 1'b1) begin
        c    = run_cnt[i] + 1;
        d[i] = (lat_cfg[i] != 8'd0) && (c >= int'(lat_cfg[i]));
      end else begin
        c    = 0;
        d[i] = spur_cfg[i];
      end
      run_cnt[i] <= c;
    end
    bus_if.child_done <= d;
  end

  // Event monitor: start order, cycle reports, done pulses, one-hot violations.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus_if.stage_cycles_valid === 1'b1) cyc_q.push_back(int'(bus_if.stage_cycles));
      if (bus_if.ap_done === 1'b1) done_total <= done_total + 1;
      if (bus_if.child_start != 5'd0 && bus_if.child_start != prev_start) begin
        for (int i = 0; i < 5; i++) if (bus_if.child_start[i]) start_q.push_back(i);
        cur_q.push_back(int'(bus_if.cur_stage));
      end
      if ($countones(bus_if.child_start) > 1) multi_total <= multi_total + 1;
    end
    prev_start <= bus_if.child_start;
  end

  task automatic start_run(input int v);
    int n;
    n = 0;
    @(negedge clock);
    while (bus_if.ap_idle !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk("idle_before_start", bus_if.ap_idle, 1);
    lat_cfg  = vecs[v].lat;
    spur_cfg = vecs[v].spur;
    start_q.delete(); cur_q.delete(); cyc_q.delete();
    bus_if.stage_en = vecs[v].en;
    bus_if.ap_start = 1'b1;
    n = 0;
    @(negedge clock);
    while (bus_if.ap_ready !== 1'b1 && n < 6) begin @(negedge clock); n++; end
    chk("ap_ready_pulse", bus_if.ap_ready, 1);
    chk("timeout_err_cleared_on_accept", bus_if.timeout_err, 0);
    acc_cyc = cyc;
    bus_if.ap_start = 1'b0;
  endtask

  task automatic finish_run(input int v);
    int n, dcyc, dbase, mbase;
    logic seen;
    n = 0; seen = 1'b0; dcyc = 0;
    dbase = done_total; mbase = multi_total;
    while (!seen && n < 400) begin
      @(negedge clock); n++;
      if (bus_if.ap_done === 1'b1) begin seen = 1'b1; dcyc = cyc; end
    end
    chk($sformatf("v%0d_ap_done_seen", v), seen, 1);
    chk($sformatf("v%0d_latency", v), dcyc + 1 - acc_cyc, vecs[v].exp_lat);
    repeat (3) @(negedge clock);
    chk($sformatf("v%0d_done_count", v), done_total - dbase, 1);
    chk($sformatf("v%0d_timeout_err", v), bus_if.timeout_err, vecs[v].exp_to);
    chk($sformatf("v%0d_child_start_idle", v), bus_if.child_start, 0);
    chk($sformatf("v%0d_onehot", v), multi_total - mbase, 0);
    chk($sformatf("v%0d_n_started", v), start_q.size(), vecs[v].n_exp);
    chk($sformatf("v%0d_n_valid", v), cyc_q.size(), vecs[v].n_exp);
    for (int k = 0; k < vecs[v].n_exp; k++) begin
      if (k < start_q.size()) chk($sformatf("v%0d_order%0d", v, k), start_q[k], vecs[v].order[k]);
      if (k < cur_q.size())   chk($sformatf("v%0d_cur_stage%0d", v, k), cur_q[k], vecs[v].order[k]);
      if (k < cyc_q.size())   chk($sformatf("v%0d_cycles%0d", v, k), cyc_q[k], vecs[v].cyc[k]);
    end
  endtask

  task automatic mid_run_reset();
    int n, dbase;
    start_run(0);
    n = 0;
    while (start_q.size() < 4 && n < 100) begin @(negedge clock); n++; end
    chk("t5_reached_stage3", (start_q.size() >= 4) && (start_q[3] == 3), 1);
    dbase = done_total;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_child_start", bus_if.child_start, 0);
    chk("t5_async_idle", bus_if.ap_idle, 1);
    chk("t5_async_done", bus_if.ap_done, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("t5_no_done", done_total - dbase, 0);
    chk("t5_idle_after_release", bus_if.ap_idle, 1);
  endtask

  task automatic back_to_back();
    int n, nr, nd;
    int rc [3];
    int dc [3];
    lat_cfg  = {5{8'd2}};
    spur_cfg = 5'b10101;
    start_q.delete(); cur_q.delete(); cyc_q.delete();
    @(negedge clock);
    bus_if.stage_en = 5'b01010;
    bus_if.ap_start = 1'b1;
    n = 0; nr = 0; nd = 0;
    while (nd < 3 && n < 400) begin
      @(negedge clock); n++;
      if (bus_if.ap_ready === 1'b1) begin
        if (nr < 3) rc[nr] = cyc;
        nr++;
        if (nr == 3) bus_if.ap_start = 1'b0;
      end
      if (bus_if.ap_done === 1'b1) begin
        if (nd < 3) dc[nd] = cyc;
        nd++;
      end
    end
    bus_if.ap_start = 1'b0;
    chk("t6_ready_count", nr, 3);
    chk("t6_done_count", nd, 3);
    for (int k = 0; k < 3; k++) if (k < nr && k < nd) chk($sformatf("t6_latency%0d", k), dc[k] + 1 - rc[k], 9);
    for (int k = 1; k < 3; k++) if (k < nr && k <= nd) chk($sformatf("t6_reaccept%0d", k), rc[k] - dc[k-1], 1);
    repeat (4) @(negedge clock);
    chk("t6_n_started", start_q.size(), 6);
    chk("t6_n_valid", cyc_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < start_q.size()) chk($sformatf("t6_order%0d", k), start_q[k], (k % 2 == 0) ? 1 : 3);
      if (k < cyc_q.size())   chk($sformatf("t6_cycles%0d", k), cyc_q[k], 2);
    end
    chk("t6_idle_end", bus_if.ap_idle, 1);
    chk("t6_no_extra_ready", bus_if.ap_ready, 0);
  endtask

  initial begin
    // T1: all five stages, 4 cycles each
    vecs[0] = mkv(5'b11111, {5{8'd4}}, 5'b00000, 5,
                  {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, {5{8'd4}}, 28, 1'b0);
    // T2: empty mask
    vecs[1] = mkv(5'b00000, {5{8'd4}}, 5'b00000, 0,
                  {5{3'd0}}, {5{8'd0}}, 3, 1'b0);
    // T3: stages 2 and 4, done in the first RUN cycle
    vecs[2] = mkv(5'b10100, {5{8'd1}}, 5'b00000, 2,
                  {9'd0, 3'd4, 3'd2}, {24'd0, 8'd1, 8'd1}, 7, 1'b0);
    // T4: stage 1 hangs, watchdog aborts at 10, stage 2 skipped
    vecs[3] = mkv(5'b00111, {8'd5, 8'd5, 8'd2, 8'd0, 8'd3}, 5'b00000, 2,
                  {9'd0, 3'd1, 3'd0}, {24'd0, 8'd10, 8'd3}, 17, 1'b1);
    // Follow-up run: clears timeout_err, spurious dones on bits 1..4
    vecs[4] = mkv(5'b00001, {5{8'd1}}, 5'b11110, 1,
                  {12'd0, 3'd0}, {32'd0, 8'd1}, 5, 1'b0);

    bus_if.ap_start = 1'b0;
    bus_if.stage_en = 5'd0;
    repeat (3) @(negedge clock);
    chk("rst_ap_idle", bus_if.ap_idle, 1);
    chk("rst_ap_ready", bus_if.ap_ready, 0);
    chk("rst_ap_done", bus_if.ap_done, 0);
    chk("rst_child_start", bus_if.child_start, 0);
    chk("rst_cur_stage", bus_if.cur_stage, 0);
    chk("rst_stage_cycles", bus_if.stage_cycles, 0);
    chk("rst_valid", bus_if.stage_cycles_valid, 0);
    chk("rst_timeout_err", bus_if.timeout_err, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_idle", bus_if.ap_idle, 1);

    for (int v = 0; v < 5; v++) begin
      start_run(v);
      finish_run(v);
    end

    mid_run_reset();
    start_run(0);
    finish_run(0);

    back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "bench time limit expired");
  end

endmodule
